// File: rtl/coax_rx_buffer_pkg.sv
// Shared definitions for the coax receive buffer: word width, stored-word flag layout
// {error,last,data} and the fetch FSM state type.
package coax_rx_buffer_pkg;

    localparam int COAX_WORD_WIDTH = 10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACK  = 2'd1,
        ST_WAIT = 2'd2
    } fetch_state_t;

    function automatic int flag_last_idx(input int data_width);
        return data_width;
    endfunction

    function automatic int flag_error_idx(input int data_width);
        return data_width + 1;
    endfunction

endpackage

// File: rtl/coax_rx_buffer_sync_fifo.sv
// First-word-fall-through FIFO with a registered head word; a pop is applied before a push
// in the same cycle, so a full FIFO accepts push+pop together.
module sync_fifo #(
    parameter int WIDTH = 12,
    parameter int DEPTH = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head,
    output logic                       empty,
    output logic                       full,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    rd_ptr_r, wr_ptr_r, rd_ptr_nxt_s;
    logic [CW-1:0]    count_r, after_pop_s, count_nxt_s;
    logic [WIDTH-1:0] head_r, head_nxt_s;
    logic             empty_r, full_r, pop_eff_s, push_eff_s;

    // Next-state pointers, occupancy and head word
    always_comb begin
        pop_eff_s    = pop && (count_r != {CW{1'b0}});
        after_pop_s  = count_r - CW'(pop_eff_s);
        push_eff_s   = push && (after_pop_s != CW'(DEPTH));
        count_nxt_s  = after_pop_s + CW'(push_eff_s);
        rd_ptr_nxt_s = rd_ptr_r + AW'(pop_eff_s);
        if (count_nxt_s == {CW{1'b0}}) begin
            head_nxt_s = {WIDTH{1'b0}};
        end else if (after_pop_s == {CW{1'b0}}) begin
            head_nxt_s = push_data;
        end else begin
            head_nxt_s = mem_r[rd_ptr_nxt_s];
        end
    end

    // Storage array write port
    always_ff @(posedge clk) begin
        if (push_eff_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

    // Pointers, count and registered status/head
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_r <= {AW{1'b0}};
            wr_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
            head_r   <= {WIDTH{1'b0}};
            empty_r  <= 1'b1;
            full_r   <= 1'b0;
        end else begin
            rd_ptr_r <= rd_ptr_nxt_s;
            wr_ptr_r <= wr_ptr_r + AW'(push_eff_s);
            count_r  <= count_nxt_s;
            head_r   <= head_nxt_s;
            empty_r  <= (count_nxt_s == {CW{1'b0}});
            full_r   <= (count_nxt_s == CW'(DEPTH));
        end
    end

    assign head  = head_r;
    assign empty = empty_r;
    assign full  = full_r;
    assign count = count_r;

endmodule

// File: rtl/coax_rx_buffer.sv
// Receive buffer between coax_rx and the host: fetches words via the data_available/read
// handshake, tags message ends and errors, and pops on synchronised host_read rising edges.
module coax_rx_buffer
    import coax_rx_buffer_pkg::*;
#(
    parameter int DATA_WIDTH  = COAX_WORD_WIDTH,
    parameter int DEPTH       = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       rx_active,
    input  logic                       rx_error,
    input  logic [DATA_WIDTH-1:0]      rx_data,
    input  logic                       rx_data_available,
    output logic                       rx_read,
    input  logic                       host_read,
    output logic [DATA_WIDTH-1:0]      dout,
    output logic                       dout_last,
    output logic                       dout_error,
    output logic                       empty,
    output logic                       full,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow,
    input  logic                       clear_overflow
);
    localparam int WW         = DATA_WIDTH + 2;
    localparam int FLAG_LAST  = flag_last_idx(DATA_WIDTH);
    localparam int FLAG_ERROR = flag_error_idx(DATA_WIDTH);

    fetch_state_t            state_r, state_nxt_s;
    logic [SYNC_STAGES-1:0]  sync_r;
    logic                    host_prev_r, pop_s;
    logic                    rx_read_r, overflow_r;
    logic                    active_prev_r, error_prev_r;
    logic [DATA_WIDTH-1:0]   stage_r, stage_nxt_s;
    logic                    stage_valid_r, stage_valid_nxt_s;
    logic                    flush_pend_r, flush_pend_nxt_s;
    logic                    marker_pend_r, marker_pend_nxt_s;
    logic                    fetch_s, active_fall_s, error_rise_s;
    logic                    push_s, fifo_full_s, fifo_empty_s;
    logic [WW-1:0]           push_word_s, head_s;

    // host_read synchroniser and rising-edge detector
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_r      <= {SYNC_STAGES{1'b0}};
            host_prev_r <= 1'b0;
        end else begin
            sync_r      <= {sync_r[SYNC_STAGES-2:0], host_read};
            host_prev_r <= sync_r[SYNC_STAGES-1];
        end
    end
    assign pop_s = sync_r[SYNC_STAGES-1] & ~host_prev_r;

    // Fetch FSM next-state logic; IDLE stalls while the FIFO is full
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (rx_data_available && !fifo_full_s) begin
                    state_nxt_s = ST_ACK;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ACK:  state_nxt_s = ST_WAIT;
            ST_WAIT: begin
                if (!rx_data_available) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_WAIT;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    assign fetch_s       = (state_r == ST_ACK);
    assign active_fall_s = active_prev_r & ~rx_active;
    assign error_rise_s  = rx_error & ~error_prev_r;

    // Staging register and push selection; at most one FIFO push per cycle
    always_comb begin
        push_s            = 1'b0;
        push_word_s       = {WW{1'b0}};
        stage_nxt_s       = stage_r;
        stage_valid_nxt_s = stage_valid_r;
        flush_pend_nxt_s  = 1'b0;
        marker_pend_nxt_s = 1'b0;
        if (marker_pend_r) begin
            push_s                  = 1'b1;
            push_word_s[FLAG_ERROR] = 1'b1;
            push_word_s[FLAG_LAST]  = 1'b1;
            if (fetch_s) begin
                stage_nxt_s       = rx_data;
                stage_valid_nxt_s = 1'b1;
            end else begin
                stage_valid_nxt_s = stage_valid_r;
            end
        end else if (error_rise_s) begin
            marker_pend_nxt_s = 1'b1;
            push_s            = stage_valid_r;
            push_word_s       = {1'b0, 1'b1, stage_r};
            stage_valid_nxt_s = fetch_s;
            if (fetch_s) begin
                stage_nxt_s = rx_data;
            end else begin
                stage_nxt_s = stage_r;
            end
        end else if (flush_pend_r) begin
            push_s            = 1'b1;
            push_word_s       = {1'b0, 1'b1, stage_r};
            stage_valid_nxt_s = fetch_s;
            if (fetch_s) begin
                stage_nxt_s = rx_data;
            end else begin
                stage_nxt_s = stage_r;
            end
        end else if (fetch_s) begin
            push_s            = stage_valid_r;
            push_word_s       = {1'b0, 1'b0, stage_r};
            stage_nxt_s       = rx_data;
            stage_valid_nxt_s = 1'b1;
            flush_pend_nxt_s  = active_fall_s;
        end else if (active_fall_s && stage_valid_r) begin
            push_s            = 1'b1;
            push_word_s       = {1'b0, 1'b1, stage_r};
            stage_valid_nxt_s = 1'b0;
        end else begin
            push_s = 1'b0;
        end
    end

    // FSM, staging, edge history and overflow registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r       <= ST_IDLE;
            rx_read_r     <= 1'b0;
            stage_r       <= {DATA_WIDTH{1'b0}};
            stage_valid_r <= 1'b0;
            flush_pend_r  <= 1'b0;
            marker_pend_r <= 1'b0;
            active_prev_r <= 1'b0;
            error_prev_r  <= 1'b0;
            overflow_r    <= 1'b0;
        end else begin
            state_r       <= state_nxt_s;
            rx_read_r     <= (state_nxt_s == ST_ACK);
            stage_r       <= stage_nxt_s;
            stage_valid_r <= stage_valid_nxt_s;
            flush_pend_r  <= flush_pend_nxt_s;
            marker_pend_r <= marker_pend_nxt_s;
            active_prev_r <= rx_active;
            error_prev_r  <= rx_error;
            // a push is dropped only if the FIFO is full and no pop frees a slot
            if (push_s && fifo_full_s && !pop_s) begin
                overflow_r <= 1'b1;
            end else if (clear_overflow) begin
                overflow_r <= 1'b0;
            end else begin
                overflow_r <= overflow_r;
            end
        end
    end

    sync_fifo #(
        .WIDTH (WW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push_s),
        .push_data (push_word_s),
        .pop       (pop_s),
        .head      (head_s),
        .empty     (fifo_empty_s),
        .full      (fifo_full_s),
        .count     (count)
    );

    assign rx_read    = rx_read_r;
    assign dout       = head_s[DATA_WIDTH-1:0];
    assign dout_last  = head_s[FLAG_LAST];
    assign dout_error = head_s[FLAG_ERROR];
    assign empty      = fifo_empty_s;
    assign full       = fifo_full_s;
    assign overflow   = overflow_r;

endmodule
